// File: rtl/dmem_controller_if.sv
// Pipeline-side request/response and memory-side strobe bus of the data-memory controller.
// The slave modport is the controller's view; master is the view of whatever drives it.
interface dmem_controller_if;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        busywait;
    logic [31:0] read_data;
    logic        access_error;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_byteen;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport slave (
        input  mem_read, mem_write, funct3, address, write_data, dmem_rdata, dmem_ack,
        output busywait, read_data, access_error, dmem_rd, dmem_wr, dmem_addr,
        output dmem_byteen, dmem_wdata
    );

    modport master (
        output mem_read, mem_write, funct3, address, write_data, dmem_rdata, dmem_ack,
        input  busywait, read_data, access_error, dmem_rd, dmem_wr, dmem_addr,
        input  dmem_byteen, dmem_wdata
    );
endinterface

// File: rtl/dmem_controller.sv
// Data-memory controller: stalls the pipeline while one load/store is carried to a
// word-wide memory with byte enables, then presents the extended result for one cycle.
module dmem_controller #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               reset,
    dmem_controller_if.slave  bus
);
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q, state_d;
    logic [29:0]   addr_q, addr_d;
    logic [1:0]    off_q, off_d;
    logic [3:0]    byteen_q, byteen_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          req, f3_ok, misal, illegal;
    logic [3:0]    be_lane;
    logic [31:0]   wd_lane;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            off_q    <= '0;
            byteen_q <= '0;
            wdata_q  <= '0;
            f3_q     <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            byteen_q <= byteen_d;
            wdata_q  <= wdata_d;
            f3_q     <= f3_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        off_d    = off_q;
        byteen_d = byteen_q;
        wdata_d  = wdata_q;
        f3_d     = f3_q;
        wr_d     = wr_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        bus.busywait = 1'b0;

        req = bus.mem_read | bus.mem_write;
        // Stores have no unsigned variants, so BU/HU encodings are rejected for writes.
        f3_ok = bus.mem_write ? (bus.funct3 inside {3'b000, 3'b001, 3'b010})
                              : (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misal = (bus.funct3[1:0] == 2'b01 && bus.address[0]) ||
                (bus.funct3[1:0] == 2'b10 && bus.address[1:0] != 2'b00);
        illegal = (bus.mem_read & bus.mem_write) | ~f3_ok | misal;

        case (bus.funct3[1:0])
            2'b00: begin
                be_lane = 4'b0001 << bus.address[1:0];
                wd_lane = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                be_lane = bus.address[1] ? 4'b1100 : 4'b0011;
                wd_lane = {2{bus.write_data[15:0]}};
            end
            default: begin
                be_lane = 4'b1111;
                wd_lane = bus.write_data;
            end
        endcase

        case (state_q)
            IDLE: begin
                bus.busywait = req & ~reset;
                if (req) begin
                    if (illegal) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end else begin
                        addr_d   = bus.address[31:2];
                        off_d    = bus.address[1:0];
                        byteen_d = be_lane;
                        wdata_d  = wd_lane;
                        f3_d     = bus.funct3;
                        wr_d     = bus.mem_write;
                        err_d    = 1'b0;
                        cnt_d    = '0;
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                bus.busywait = 1'b1;
                if (bus.dmem_ack) begin
                    rdata_d = wr_q ? 32'd0 : load_ext(f3_q, off_q, bus.dmem_rdata);
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dmem_rd      = (state_q == ACCESS) & ~wr_q;
    assign bus.dmem_wr      = (state_q == ACCESS) & wr_q;
    assign bus.dmem_addr    = addr_q;
    assign bus.dmem_byteen  = byteen_q;
    assign bus.dmem_wdata   = wdata_q;
    assign bus.read_data    = rdata_q;
    assign bus.access_error = (state_q == DONE) & err_q;
endmodule
